// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and per-bit state type for the input debouncer
package debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000;
    localparam int CNT_W_DEFAULT           = 16;

    typedef enum logic {
        DB_IDLE     = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchroniser, stability counter and edge pulse generator
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ena_i,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o,
    output logic commit_o
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    db_state_e        state;

    // The counter and level only advance while enabled; the synchroniser always runs.
    always_comb begin
        s1_d   = din_i;
        s2_d   = s1_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        state  = (s2_q != dout_q) ? DB_COUNTING : DB_IDLE;
        if (ena_i) begin
            if (state == DB_IDLE) begin
                cnt_d = '0;
            end else if (cnt_q == TERMINAL) begin
                dout_d = s2_q;
                cnt_d  = '0;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o   = dout_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign commit_o = rise_d | fall_d;

endmodule

// File: rtl/ui_debounce_sync.sv
// rtl/ui_debounce_sync.sv - per-pin synchronise and debounce stage feeding the flip-flop core
module ui_debounce_sync
    import debounce_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    logic [WIDTH-1:0] commit;
    logic             any_edge_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i    (clk),
            .rst_n_i  (rst_n),
            .ena_i    (ena),
            .din_i    (din[i]),
            .dout_o   (dout[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .commit_o (commit[i])
        );
    end

    // Registered from the per-bit next-pulse strobes so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_edge_q <= 1'b0;
        end else begin
            any_edge_q <= |commit;
        end
    end

    assign any_edge = any_edge_q;

endmodule

// File: tb/tb_ui_debounce_sync.sv
// tb/tb_ui_debounce_sync.sv - randomized and directed self-checking bench for ui_debounce_sync
module tb_ui_debounce_sync;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] din;
    logic [W-1:0] dout, rise, fall;
    logic         any_edge;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_dout = '0, m_rise = '0, m_fall = '0;
    logic         m_any = 1'b0;
    int           m_run [W];

    ui_debounce_sync #(
        .WIDTH           (W),
        .CNT_W           (16),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .din      (din),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .any_edge (any_edge)
    );

    always #5 clk = ~clk;

    // Reference: a bit's level flips once its synchronised input has disagreed
    // with it for D consecutive enabled edges; pulses mark that flip.
    task automatic model_step();
        logic [W-1:0] nd;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_dout = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            nd = m_dout;
            if (ena) begin
                for (int i = 0; i < W; i++) begin
                    if (m_s2[i] != m_dout[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == D) begin
                            nd[i]    = m_s2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_rise = nd & ~m_dout;
            m_fall = ~nd & m_dout;
            m_any  = |(m_rise | m_fall);
            m_dout = nd;
            m_s2   = m_s1;
            m_s1   = din;
        end
    endtask

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) m_run[i] = 0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            cmp("dout", dout, m_dout);
            cmp("rise", rise, m_rise);
            cmp("fall", fall, m_fall);
            cmp("any_edge", {7'b0, any_edge}, {7'b0, m_any});
        end
    end

    task automatic lit(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] mdl, input logic [W-1:0] exp);
        cmp(name, act, exp);
        cmp({name, "_model"}, mdl, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; din = 8'hFF;
        tick(3);
        lit("rst_dout", dout, m_dout, 8'h00);
        lit("rst_rise", rise, m_rise, 8'h00);
        lit("rst_any", {7'b0, any_edge}, {7'b0, m_any}, 8'h00);
        rst_n = 1'b1;
        tick(5);
        lit("rel_dout_early", dout, m_dout, 8'h00);
        tick(1);
        lit("rel_dout", dout, m_dout, 8'hFF);
        lit("rel_rise", rise, m_rise, 8'hFF);
        lit("rel_any", {7'b0, any_edge}, {7'b0, m_any}, 8'h01);
        tick(1);
        lit("rel_rise_off", rise, m_rise, 8'h00);
        lit("rel_any_off", {7'b0, any_edge}, {7'b0, m_any}, 8'h00);

        din = 8'h00; tick(8);
        lit("clr_dout", dout, m_dout, 8'h00);
        din = 8'h01; tick(5);
        lit("clean_early", dout, m_dout, 8'h00);
        tick(1);
        lit("clean_dout", dout, m_dout, 8'h01);
        lit("clean_rise", rise, m_rise, 8'h01);
        tick(1);
        lit("clean_rise_off", rise, m_rise, 8'h00);

        din = 8'h09; tick(3); din = 8'h01; tick(8);
        lit("glitch1_dout", dout, m_dout, 8'h01);
        din = 8'h09; tick(3); din = 8'h01; tick(8);
        lit("glitch2_dout", dout, m_dout, 8'h01);
        din = 8'h09; tick(6);
        lit("hold_dout", dout, m_dout, 8'h09);
        lit("hold_rise", rise, m_rise, 8'h08);

        din = 8'h0D; tick(3);
        ena = 1'b0; tick(10);
        lit("frz_dout", dout, m_dout, 8'h09);
        ena = 1'b1; tick(2);
        lit("frz_resume_early", dout, m_dout, 8'h09);
        tick(1);
        lit("frz_dout_commit", dout, m_dout, 8'h0D);
        lit("frz_rise", rise, m_rise, 8'h04);

        din = 8'h4F; tick(8);
        lit("pre_fall_dout", dout, m_dout, 8'h4F);
        din = 8'h0D; tick(6);
        lit("fall_pair", fall, m_fall, 8'h42);
        lit("fall_any", {7'b0, any_edge}, {7'b0, m_any}, 8'h01);
        lit("fall_dout", dout, m_dout, 8'h0D);
        tick(1);
        lit("fall_off", fall, m_fall, 8'h00);

        din = 8'h8D; tick(5);
        lit("mid_dout", dout, m_dout, 8'h0D);
        rst_n = 1'b0; tick(1);
        lit("mid_rst_dout", dout, m_dout, 8'h00);
        lit("mid_rst_rise", rise, m_rise, 8'h00);
        tick(1);
        rst_n = 1'b1; tick(6);
        lit("mid_recommit", dout, m_dout, 8'h8D);
        lit("mid_recommit_rise", rise, m_rise, 8'h8D);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) din = din ^ (8'(1) << $urandom_range(0, 7));
            ena   = ($urandom_range(0, 19) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            tick(1);
        end
        rst_n = 1'b1; ena = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
